// File: rtl/mdu_scheduler_pkg.sv
// mdu_scheduler_pkg: shared definitions for the HI/LO multiply/divide issue controller.
//   - MDU op encodings (3-bit req_op field from E-stage decode)
//   - scheduler FSM state encoding
//   - default multiply/divide latencies
package mdu_scheduler_pkg;

    localparam int unsigned MUL_LAT_DEFAULT = 5;
    localparam int unsigned DIV_LAT_DEFAULT = 10;
    localparam int unsigned CNT_W_DEFAULT   = 4;

    typedef enum logic [2:0] {
        OpMultu = 3'd0,
        OpMult  = 3'd1,
        OpDivu  = 3'd2,
        OpDiv   = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5,
        OpMfhi  = 3'd6,
        OpMflo  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2
    } mdu_state_e;

    // Ops that occupy the unit for a full multiply/divide latency.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// mdu_lat_counter: loadable down-counter modelling the MDU's busy latency.
// Ports:
//   clk, reset   clock, synchronous active-high reset (value -> 0)
//   load         load load_val this edge (takes priority over counting)
//   load_val     value loaded on load
//   value        current count
//   zero         value == 0
// The counter decrements each cycle while non-zero and holds at zero.
module mdu_lat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: issue and hazard controller for the HI/LO multiply/divide unit.
// Accepts or stalls each E-stage MDU request and emits the single-cycle strobes the
// datapath latches on. Unit latency is modelled internally, so stall depends on
// this block only.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   req_valid     E stage holds an MDU instruction
//   req_op        MDU op code (mdu_op_e)
//   divisor_zero  E-stage divisor operand is zero
//   flush         E-stage instruction is being killed
//   stall         hold F/D/E (combinational)
//   start         datapath starts a multiply/divide (combinational)
//   mul_op        00 multu, 01 mult, 10 divu, 11 div while start=1, else 00
//   wr_hi, wr_lo  write HI/LO from SrcA this edge (combinational)
//   rd_hi         MFHI/MFLO result select, 1=HI (combinational)
//   busy          unit occupied (registered)
//   div0_flag     sticky divide-by-zero indicator, cleared by reset only
//   stall_cnt     saturating count of stall cycles
module mdu_scheduler
    import mdu_scheduler_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
    parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic        divisor_zero,
    input  logic        flush,
    output logic        stall,
    output logic        start,
    output logic [1:0]  mul_op,
    output logic        wr_hi,
    output logic        wr_lo,
    output logic        rd_hi,
    output logic        busy,
    output logic        div0_flag,
    output logic [15:0] stall_cnt
);

    mdu_state_e       state_q, state_d;
    logic             div0_flag_q, div0_flag_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic             live_req;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;

    assign busy = (state_q != StIdle);

    // Reset and flush both kill the request for this cycle.
    assign live_req = req_valid & ~flush & ~reset;
    assign accept   = live_req & ~busy;

    assign cnt_load     = accept & is_arith_op(req_op);
    assign cnt_load_val = is_div_op(req_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    mdu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cnt_load) begin
                    state_d = is_div_op(req_op) ? StDiv : StMul;
                end
            end
            StMul, StDiv: begin
                // Zero check guards against a counter that never got loaded.
                if ((cnt_value == CNT_W'(1)) || cnt_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        stall  = 1'b0;
        start  = 1'b0;
        mul_op = 2'b00;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        rd_hi  = 1'b0;
        if (live_req && busy) begin
            stall = 1'b1;
        end else if (accept) begin
            unique case (mdu_op_e'(req_op))
                OpMultu, OpMult, OpDivu, OpDiv: begin
                    start  = 1'b1;
                    mul_op = req_op[1:0];
                end
                OpMthi: wr_hi = 1'b1;
                OpMtlo: wr_lo = 1'b1;
                OpMfhi: rd_hi = 1'b1;
                OpMflo: rd_hi = 1'b0;
                default: ;
            endcase
        end
    end

    // Sticky divide-by-zero flag and saturating stall counter
    always_comb begin
        div0_flag_d = div0_flag_q;
        if (start && is_div_op(req_op) && divisor_zero) begin
            div0_flag_d = 1'b1;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div0_flag_q <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            div0_flag_q <= div0_flag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign div0_flag = div0_flag_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed testbench for mdu_scheduler. Inputs change 1ns after the rising edge;
// outputs are sampled 2ns after the rising edge, well away from the next one.
module tb_mdu_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic        divisor_zero;
    logic        flush;
    logic        stall;
    logic        start;
    logic [1:0]  mul_op;
    logic        wr_hi;
    logic        wr_lo;
    logic        rd_hi;
    logic        busy;
    logic        div0_flag;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] MULTU = 3'd0, MULT = 3'd1, DIVU = 3'd2, DIV = 3'd3;
    localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, MFHI = 3'd6, MFLO = 3'd7;

    always #5 clk = ~clk;

    mdu_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .divisor_zero (divisor_zero),
        .flush        (flush),
        .stall        (stall),
        .start        (start),
        .mul_op       (mul_op),
        .wr_hi        (wr_hi),
        .wr_lo        (wr_lo),
        .rd_hi        (rd_hi),
        .busy         (busy),
        .div0_flag    (div0_flag),
        .stall_cnt    (stall_cnt)
    );

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_op       = MULTU;
        divisor_zero = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b1;
        req_op    = MULT;
        flush     = 1'b0;
        divisor_zero = 1'b0;
        tick();
        #1;
        checks++;
        if ({start, stall, wr_hi, wr_lo} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes: got %b want 0000", {start, stall, wr_hi, wr_lo});
        end
        idle_inputs();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, div0_flag, stall_cnt} !== 18'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b div0=%b stall_cnt=%0d want 0 0 0",
                     busy, div0_flag, stall_cnt);
        end
    endtask

    task automatic test_mult_latency();
        do_reset();
        req_valid = 1'b1;
        req_op    = MULT;
        #1;
        checks++;
        if (start !== 1'b1 || mul_op !== 2'b01 || stall !== 1'b0) begin
            failures++;
            $display("FAIL mult_issue: start=%b mul_op=%b stall=%b want 1 01 0",
                     start, mul_op, stall);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            req_valid = 1'b0;
            #1;
            checks++;
            if (busy !== (c <= 5)) begin
                failures++;
                $display("FAIL mult_busy_c%0d: got %b want %b", c, busy, (c <= 5));
            end
        end
    endtask

    task automatic test_divu_mflo();
        int nstall;
        int accepted_at;
        do_reset();
        req_valid = 1'b1;
        req_op    = DIVU;
        #1;
        checks++;
        if (start !== 1'b1 || mul_op !== 2'b10) begin
            failures++;
            $display("FAIL divu_issue: start=%b mul_op=%b want 1 10", start, mul_op);
        end
        tick();
        req_op      = MFLO;
        nstall      = 0;
        accepted_at = 0;
        for (int c = 1; c <= 30 && accepted_at == 0; c++) begin
            #1;
            if (stall === 1'b1) begin
                nstall++;
            end else begin
                accepted_at = c;
                checks++;
                if (rd_hi !== 1'b0 || start !== 1'b0) begin
                    failures++;
                    $display("FAIL mflo_accept: rd_hi=%b start=%b want 0 0", rd_hi, start);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (accepted_at != 11 || nstall != 10) begin
            failures++;
            $display("FAIL mflo_stall_len: accepted_at=%0d stalls=%0d want 11 10",
                     accepted_at, nstall);
        end
        #1;
        checks++;
        if (stall_cnt !== 16'd10) begin
            failures++;
            $display("FAIL stall_cnt_divu: got %0d want 10", stall_cnt);
        end
    endtask

    task automatic test_mthi();
        do_reset();
        req_valid = 1'b1;
        req_op    = MTHI;
        #1;
        checks++;
        if (wr_hi !== 1'b1 || wr_lo !== 1'b0 || start !== 1'b0) begin
            failures++;
            $display("FAIL mthi_idle: wr_hi=%b wr_lo=%b start=%b want 1 0 0",
                     wr_hi, wr_lo, start);
        end
        tick();
        req_op = MTLO;
        #1;
        checks++;
        if (busy !== 1'b0 || wr_lo !== 1'b1 || wr_hi !== 1'b0) begin
            failures++;
            $display("FAIL mtlo_idle: busy=%b wr_lo=%b wr_hi=%b want 0 1 0", busy, wr_lo, wr_hi);
        end
        // MULT, then MTHI held while busy: stalls cycles 1..5, writes at 6.
        tick();
        req_op = MULT;
        tick();
        req_op = MTHI;
        for (int c = 1; c <= 6; c++) begin
            #1;
            checks++;
            if (stall !== (c <= 5) || wr_hi !== (c == 6)) begin
                failures++;
                $display("FAIL mthi_busy_c%0d: stall=%b wr_hi=%b want %b %b",
                         c, stall, wr_hi, (c <= 5), (c == 6));
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_div0();
        do_reset();
        req_valid    = 1'b1;
        req_op       = DIV;
        divisor_zero = 1'b1;
        #1;
        checks++;
        if (start !== 1'b1 || mul_op !== 2'b11 || div0_flag !== 1'b0) begin
            failures++;
            $display("FAIL div0_issue: start=%b mul_op=%b div0=%b want 1 11 0",
                     start, mul_op, div0_flag);
        end
        for (int c = 1; c <= 12; c++) begin
            tick();
            idle_inputs();
            #1;
            checks++;
            if (busy !== (c <= 10) || div0_flag !== 1'b1) begin
                failures++;
                $display("FAIL div0_c%0d: busy=%b div0=%b want %b 1",
                         c, busy, div0_flag, (c <= 10));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req_valid = 1'b1;
        req_op    = MULT;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_busy_c3: got %b want 1", busy);
        end
        tick();
        reset     = 1'b0;
        req_valid = 1'b1;
        req_op    = DIV;
        #1;
        checks++;
        if (busy !== 1'b0 || start !== 1'b1 || stall !== 1'b0 || mul_op !== 2'b11) begin
            failures++;
            $display("FAIL midreset_c4: busy=%b start=%b stall=%b mul_op=%b want 0 1 0 11",
                     busy, start, stall, mul_op);
        end
        tick();
        req_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_div_busy: got %b want 1", busy);
        end
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 1'b1;
        req_op    = MULT;
        flush     = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_mult: start=%b stall=%b want 0 0", start, stall);
        end
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy: got %b want 0", busy);
        end
        // MULT now accepted; next cycle a flushed MFHI must not stall.
        tick();
        req_op = MFHI;
        flush  = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || rd_hi !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_mfhi: stall=%b rd_hi=%b busy=%b want 0 0 1", stall, rd_hi, busy);
        end
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'd0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL flush_cnt: stall_cnt=%0d stall=%b want 0 1", stall_cnt, stall);
        end
        tick();
        req_valid = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL stall_cnt_one: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 1'b1;
        req_op    = MULTU;
        #1;
        checks++;
        if (start !== 1'b1 || mul_op !== 2'b00) begin
            failures++;
            $display("FAIL b2b_first: start=%b mul_op=%b want 1 00", start, mul_op);
        end
        tick();
        req_op = MFHI;
        for (int c = 1; c <= 6; c++) begin
            #1;
            checks++;
            if (stall !== (c <= 5) || rd_hi !== (c == 6)) begin
                failures++;
                $display("FAIL b2b_c%0d: stall=%b rd_hi=%b want %b %b",
                         c, stall, rd_hi, (c <= 5), (c == 6));
            end
            tick();
        end
        req_op = DIVU;
        #1;
        checks++;
        if (start !== 1'b1 || busy !== 1'b0 || mul_op !== 2'b10) begin
            failures++;
            $display("FAIL b2b_next: start=%b busy=%b mul_op=%b want 1 0 10", start, busy, mul_op);
        end
        tick();
        req_valid = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_cnt: stall_cnt=%0d busy=%b want 5 1", stall_cnt, busy);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_mult_latency();
        test_divu_mflo();
        test_mthi();
        test_div0();
        test_reset_mid_op();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_scheduler.md
# mdu_scheduler

Issue and hazard controller for the HI/LO multiply/divide unit in the pipelined MIPS core. Sits between the E-stage decode of MDU instructions (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO) and the multiply/divide datapath. It accepts or stalls each MDU request, emits the single-cycle start/write strobes the datapath latches on, and models the unit's latency with its own counter. A stall therefore comes from this block alone, not from a datapath busy flag.

## Interface
- MUL_LAT, 5, busy cycles after a multiply is accepted (≥1)
- DIV_LAT, 10, busy cycles after a divide is accepted (≥1)
- CNT_W, 4, latency counter width; must hold max(MUL_LAT, DIV_LAT)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  E-stage holds an MDU instruction this cycle
- req_op  in  3  MDU op code (encoding in shared package)
- divisor_zero  in  1  E-stage divisor operand equals 0
- flush  in  1  E-stage instruction is being killed (exception/eret)
- stall  out  1  hold F/D/E, bubble into M (combinational)
- start  out  1  datapath latches operands and begins op (combinational)
- mul_op  out  2  00 multu, 01 mult, 10 divu, 11 div; valid when start=1, else 00
- wr_hi  out  1  write HI from SrcA this edge (combinational)
- wr_lo  out  1  write LO from SrcA this edge (combinational)
- rd_hi  out  1  MFHI/MFLO result select: 1=HI, 0=LO (combinational)
- busy  out  1  unit occupied (registered)
- div0_flag  out  1  sticky: a divide by zero was issued; cleared by reset only
- stall_cnt  out  16  saturating count of cycles with stall=1

## Operation
- Each cycle, let accept = req_valid & ~flush & ~busy.
- States: IDLE, MUL, DIV. busy = (state != IDLE).
- IDLE, accept with MULT/MULTU: start=1, mul_op=01/00, cnt←MUL_LAT, next state MUL.
- IDLE, accept with DIV/DIVU: start=1, mul_op=11/10, cnt←DIV_LAT, next state DIV. If divisor_zero=1, set div0_flag. The divide still issues; the HI/LO result is architecturally undefined.
- IDLE, accept with MTHI/MTLO: wr_hi or wr_lo=1 for that cycle only. No state change, no busy.
- IDLE, accept with MFHI/MFLO: rd_hi=1 for MFHI, 0 for MFLO. No state change, no stall.
- MUL/DIV: cnt decrements each cycle. When cnt==1 the next state is IDLE with cnt←0.
- stall = req_valid & ~flush & busy. Every MDU op stalls while busy, including MF/MT. Non-MDU instructions never stall.
- A stalled request is not remembered. The pipeline re-presents it every cycle until it is accepted.
- flush suppresses all strobes and stall for that cycle. flush while busy does not abort the in-flight op; the counter keeps running.
- stall_cnt increments on every cycle with stall=1 and saturates at 0xFFFF.
- An invalid req_op (unused encodings) is treated as a no-op: no strobe, no stall.

## Timing
- Reset values: state IDLE, cnt 0, busy 0, div0_flag 0, stall_cnt 0. All combinational outputs are 0 when req_valid=0.
- Reset mid-operation returns to IDLE on the next edge. The in-flight op is abandoned.
- Accept at edge T: busy=1 for cycles T+1 … T+LAT and busy=0 at T+LAT+1.
- A dependent MDU op presented at T+1 stalls exactly LAT cycles and is accepted in cycle T+LAT+1.
- Back-to-back issue: a new op may be accepted in the first cycle busy=0. No dead cycle.
- req_valid and flush in the same cycle: flush wins, stall=0.
- reset and req_valid in the same cycle: reset wins, no strobes.

## Structure
- Shared package/header (alongside the existing macro header) holds:
  - MDU op encodings: MULTU=0, MULT=1, DIVU=2, DIV=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7
  - state encodings
  - default MUL_LAT/DIV_LAT
- One sub-module, mdu_lat_counter: loadable down-counter with load/value/zero outputs, instantiated once.
- The datapath is not instantiated here; it is wired alongside in the E stage.

## Test plan
- Reset, then MULT at cycle 0 → start=1, mul_op=01; busy high cycles 1–5, low at 6.
- DIVU accepted, then MFLO held valid → stall=1 for exactly 10 cycles, MFLO accepted on cycle 11 with rd_hi=0; stall_cnt=10.
- MTHI in IDLE → wr_hi=1 for one cycle, busy stays 0. MTHI while MUL busy → stall=1, no wr_hi until busy drops.
- DIV with divisor_zero=1 → start=1, div0_flag=1 and still 1 after the op completes; busy 10 cycles.
- MULT accepted, reset asserted at cycle 3 → busy=0 at cycle 4. A new DIV at cycle 4 is accepted immediately.
- MULT with flush=1 → no start, busy stays 0. Busy plus flushed MFHI → stall=0 and stall_cnt unchanged.
